// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per cycle.
// Optional invalid-digit detection is enabled with BCD_TO_BINARY_SEQ_ERR_EN.
module bcd_to_binary_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // state  | meaning
  // IDLE   | waiting for start; bin/err hold the last result
  // CONV   | one shift-and-correct iteration per cycle
  // DONE   | one-cycle done pulse, then back to IDLE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int            HW   = 4 * DIGITS;
  localparam int            CW   = $clog2(HW) + 1;
  localparam logic [CW-1:0] LAST = CW'(HW - 1);

  logic [1:0]          state;
  logic [2*HW-1:0]     sreg;
  logic [2*HW-1:0]     sreg_nxt;
  logic [CW-1:0]       cnt;
  logic                bad_digit;
  logic [HW+BIN_W-1:0] bin_ext;

`ifdef BCD_TO_BINARY_SEQ_ERR_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  // Shift right, then pull each upper-half digit that reached 8+ back down by 3.
  always_comb begin
    sreg_nxt = sreg >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sreg_nxt[HW + 4*i +: 4] >= 4'd8)
        sreg_nxt[HW + 4*i +: 4] = sreg_nxt[HW + 4*i +: 4] - 4'd3;
    end
  end

  // Zero-extend so any BIN_W (smaller or larger than the lower half) slices cleanly.
  assign bin_ext = {{BIN_W{1'b0}}, sreg_nxt[HW-1:0]};

  assign busy = (state == S_CONV);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg <= {bcd, {HW{1'b0}}};
            cnt  <= '0;
            bin  <= '0;
            err  <= 1'b0;
            if (bad_digit) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_CONV;
            end
          end
        end
        S_CONV: begin
          sreg <= sreg_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            bin   <= bin_ext[BIN_W-1:0];
            err   <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: expected results are queued at start
// and compared when done pulses.
module tb_bcd_to_binary_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] bcd;
  logic [6:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  logic [6:0] exp_q[$];
  logic       chk_q[$];

  bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Start a conversion at the next negedge and follow it to its done pulse.
  task automatic run_conv(input logic [7:0] v, input logic [6:0] exp_bin,
                          input logic chk_bin, input logic exp_err,
                          input int exp_lat, input int exp_busy);
    int lat;
    int busy_cnt;
    logic [6:0] e;
    logic c;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL idle_done: done=%b required 0", done);
    end
    bcd = v;
    start = 1'b1;
    exp_q.push_back(exp_bin);
    chk_q.push_back(chk_bin);
    @(negedge clk);
    start = 1'b0;
    bcd = 8'hxx;
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    c = chk_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: bcd=%h no done within %0d cycles", v, lat);
      return;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency: bcd=%h got %0d cycles required %0d", v, lat, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_busy) begin
      errors++;
      $display("FAIL busy_cycles: bcd=%h got %0d required %0d", v, busy_cnt, exp_busy);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: bcd=%h busy=%b required 0", v, busy);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err: bcd=%h got %b required %b", v, err, exp_err);
    end
    if (c) begin
      checks++;
      if (bin !== e) begin
        errors++;
        $display("FAIL bin: bcd=%h got %0d required %0d", v, bin, e);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    bcd = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bin, busy, done, err} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: bin=%0d busy=%b done=%b err=%b required all 0", bin, busy, done, err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bin, busy, done, err} !== 10'd0) begin
      errors++;
      $display("FAIL after_release: bin=%0d busy=%b done=%b err=%b required all 0", bin, busy, done, err);
    end
  endtask

  task automatic test_convert;
    run_conv(8'h37, 7'd37, 1'b1, 1'b0, 9, 8);
    run_conv(8'h99, 7'd99, 1'b1, 1'b0, 9, 8);
    run_conv(8'h00, 7'd0,  1'b1, 1'b0, 9, 8);
    run_conv(8'h10, 7'd10, 1'b1, 1'b0, 9, 8);
    run_conv(8'h09, 7'd9,  1'b1, 1'b0, 9, 8);
    run_conv(8'h90, 7'd90, 1'b1, 1'b0, 9, 8);
    for (int k = 0; k < 6; k++) begin
      int n;
      logic [7:0] v;
      n = $urandom_range(0, 99);
      v = {4'(n / 10), 4'(n % 10)};
      run_conv(v, 7'(n), 1'b1, 1'b0, 9, 8);
    end
  endtask

  task automatic test_invalid;
`ifdef BCD_TO_BINARY_SEQ_ERR_EN
    run_conv(8'h3A, 7'd0, 1'b1, 1'b1, 1, 0);
    run_conv(8'hF1, 7'd0, 1'b1, 1'b1, 1, 0);
    run_conv(8'h25, 7'd25, 1'b1, 1'b0, 9, 8);
`else
    run_conv(8'h3A, 7'd0, 1'b0, 1'b0, 9, 8);
`endif
  endtask

  task automatic test_ignore_start;
    int dones;
    @(negedge clk);
    bcd = 8'h42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bcd = 8'h15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (bin !== 7'd42) begin
          errors++;
          $display("FAIL ignore_bin: got %0d required 42", bin);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d pulses required 1", dones);
    end
  endtask

  task automatic test_reset_abort;
    int dones;
    @(negedge clk);
    bcd = 8'h58;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bin, busy, done, err} !== 10'd0) begin
      errors++;
      $display("FAIL abort_outputs: bin=%0d busy=%b done=%b err=%b required all 0", bin, busy, done, err);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses required 0", dones);
    end
    run_conv(8'h58, 7'd58, 1'b1, 1'b0, 9, 8);
  endtask

  task automatic test_back_to_back;
    run_conv(8'h12, 7'd12, 1'b1, 1'b0, 9, 8);
    run_conv(8'h87, 7'd87, 1'b1, 1'b0, 9, 8);
    run_conv(8'h64, 7'd64, 1'b1, 1'b0, 9, 8);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bin !== 7'd64) begin
      errors++;
      $display("FAIL hold_after_done: done=%b bin=%0d required done=0 bin=64", done, bin);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_invalid();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
